dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 64 x 16 data memory between the CPU load/store unit (port 0) and the debug/DMA loader (port 1). It issues at most one access per cycle to the memory's wr_en/rd_en/mem_address/data_in pins and routes the registered read data back to the requester that issued the read. It also supports short locked sequences, such as read-modify-write, with a bounded lock duration. The block sits between the CPU datapath and the data memory instance.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared 64x16 data memory, with bounded locks.
// Define DMEM_ARB_RR_EN for round-robin ties; default is port 0 priority.
module dmem_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [5:0]  p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [5:0]  p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [15:0] p0_rdata,
  output logic [15:0] p1_rdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    ARB,
    OWN0,
    OWN1
  } state_t;

  localparam logic [4:0] LMAX = 5'(LOCK_MAX);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       last;
  logic       tie1;
  logic       g0, g1, gn, gl;
  logic       own_req, own_lock;

`ifdef DMEM_ARB_RR_EN
  assign tie1 = ~last;
`else
  assign tie1 = 1'b0;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      ARB: begin
        g1 = p1_req & (~p0_req | tie1);
        g0 = p0_req & ~g1;
      end
      OWN0:    g0 = p0_req;
      OWN1:    g1 = p1_req;
      default: ;
    endcase
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign gn = g0 | g1;
  assign gl = (g0 & p0_lock) | (g1 & p1_lock);

  assign own_req  = (state == OWN1) ? p1_req  : p0_req;
  assign own_lock = (state == OWN1) ? p1_lock : p0_lock;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ARB: begin
        // A one-cycle lock budget is used up by the entry access itself
        if (gn && gl && (LMAX > 5'd1)) begin
          state_nx = g1 ? OWN1 : OWN0;
          cnt_nx   = 4'd1;
        end
      end
      OWN0, OWN1: begin
        if (gn) begin
          if (gl && ((5'(cnt) + 5'd1) < LMAX)) begin
            cnt_nx = cnt + 4'd1;
          end else begin
            state_nx = ARB;
            cnt_nx   = 4'd0;
          end
        end else if (!own_req && !own_lock) begin
          state_nx = ARB;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = ARB;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      cnt       <= 4'd0;
      last      <= 1'b1;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      if (gn) last <= g1;
      p0_rvalid <= g0 & ~p0_we;
      p1_rvalid <= g1 & ~p1_we;
    end
  end

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign mem_wr_en = (g0 & p0_we) | (g1 & p1_we);
  assign mem_rd_en = (g0 & ~p0_we) | (g1 & ~p1_we);
  assign mem_addr  = g1 ? p1_addr : p0_addr;
  assign mem_wdata = g1 ? p1_wdata : p0_wdata;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a rule-level model.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p0_lock = 0;
  logic [5:0]  p0_addr = 0;
  logic [15:0] p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [5:0]  p1_addr = 0;
  logic [15:0] p1_wdata = 0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int          port;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          started = 0;

  logic        n_rst;
  logic        s_req[2], s_we[2], s_lock[2];
  logic [5:0]  s_addr[2];
  logic [15:0] s_wd[2];

  logic [15:0] mm [64];
  int          own = -1;
  int          cnt = 0;
  int          last = 1;
  int          mg = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int g;
    logic we;
    logic [5:0] a;
    g = -1;
    cyc++;
    if (!n_rst) begin
      if (own >= 0) begin
        if (s_req[own]) g = own;
      end else if (s_req[0] && s_req[1]) begin
`ifdef DMEM_ARB_RR_EN
        g = (last == 0) ? 1 : 0;
`else
        g = 0;
`endif
      end else if (s_req[0]) g = 0;
      else if (s_req[1]) g = 1;
    end
    mg = g;
    we = (g >= 0) ? s_we[g] : 1'b0;
    a  = (g == 1) ? s_addr[1] : s_addr[0];
    chk("p0_gnt", 32'(p0_gnt), 32'(g == 0));
    chk("p1_gnt", 32'(p1_gnt), 32'(g == 1));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(g >= 0 && we));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(g >= 0 && !we));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("mem_wdata", 32'(mem_wdata),
        32'((g == 1) ? s_wd[1] : s_wd[0]));
    if (n_rst) begin
      chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
      sbq.delete();
      own = -1;
      cnt = 0;
      last = 1;
    end else if (g >= 0) begin
      last = g;
      if (we) mm[a] = s_wd[g];
      else sbq.push_back('{port: g, data: mm[a], cyc: cyc});
      if (own < 0) begin
        if (s_lock[g] && LOCK_MAX > 1) begin
          own = g;
          cnt = 1;
        end
      end else if (s_lock[g] && cnt + 1 < LOCK_MAX) begin
        cnt++;
      end else begin
        own = -1;
        cnt = 0;
      end
    end else if (own >= 0 && !s_req[own] && !s_lock[own]) begin
      own = -1;
      cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = n_rst;
    p0_req = s_req[0]; p0_we = s_we[0]; p0_lock = s_lock[0];
    p0_addr = s_addr[0]; p0_wdata = s_wd[0];
    p1_req = s_req[1]; p1_we = s_we[1]; p1_lock = s_lock[1];
    p1_addr = s_addr[1]; p1_wdata = s_wd[1];
    @(negedge clk);
    model_step();
  endtask

  task automatic set(input int p, input logic r, input logic w,
                     input logic l, input logic [5:0] a,
                     input logic [15:0] d);
    s_req[p] = r; s_we[p] = w; s_lock[p] = l;
    s_addr[p] = a; s_wd[p] = d;
  endtask

  task automatic idle(input int n);
    set(0, 0, 0, 0, 6'd0, 16'h0);
    set(1, 0, 0, 0, 6'd0, 16'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic gen(input int p);
    logic [5:0] a;
    a = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
    set(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
        $urandom_range(0, 3) == 0, a, 16'($urandom));
  endtask

  // rvalid scoreboard monitor
  always begin
    @(negedge clk);
    #2;
    if (started && !rst) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.port == 0 ? "p0_rvalid" : "p1_rvalid",
            32'(e.port == 0 ? p0_rvalid : p1_rvalid), 32'd1);
        chk("other_rvalid",
            32'(e.port == 0 ? p1_rvalid : p0_rvalid), 32'd0);
        chk("rdata", 32'(e.port == 0 ? p0_rdata : p1_rdata),
            32'(e.data));
      end else if (p0_rvalid || p1_rvalid) begin
        chk("spurious_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
      end
    end
  end

  initial begin
    int p0run;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'(i * 16'h0101 + 7);
      mm[i]  = 16'(i * 16'h0101 + 7);
    end
    n_rst = 1'b1;
    set(0, 1, 1, 1, 6'd1, 16'h1111);
    set(1, 1, 0, 1, 6'd2, 16'h2222);
    tick();
    started = 1;
    tick();
    n_rst = 1'b0;
    idle(2);

    set(0, 1, 1, 0, 6'd5, 16'h1234); tick();
    idle(1);
    set(1, 1, 0, 0, 6'd5, 16'h0); tick();
    idle(2);

    set(0, 1, 0, 0, 6'd10, 16'h0);
    set(1, 1, 0, 0, 6'd11, 16'h0);
    for (int i = 0; i < 4; i++) tick();
    idle(2);

    n_rst = 1'b1; idle(1); n_rst = 1'b0;
    set(0, 1, 0, 1, 6'd3, 16'h0);
    set(1, 1, 0, 0, 6'd4, 16'h0); tick();
    set(0, 1, 1, 0, 6'd3, 16'hBEEF); tick();
    set(0, 0, 0, 0, 6'd0, 16'h0); tick();
    idle(2);

    n_rst = 1'b1; idle(1); n_rst = 1'b0;
    p0run = 0;
    set(0, 1, 0, 1, 6'd7, 16'h0);
    set(1, 1, 0, 0, 6'd8, 16'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mg == 0 && i == p0run) p0run++;
    end
`ifdef DMEM_ARB_RR_EN
    chk("lock_timeout_run", 32'(p0run), 32'(LOCK_MAX));
`else
    chk("lock_timeout_run", 32'(p0run), 32'd12);
`endif
    idle(2);

    set(0, 1, 1, 0, 6'd63, 16'hA5A5); tick();
    set(0, 0, 0, 0, 6'd0, 16'h0);
    set(1, 1, 0, 0, 6'd63, 16'h0); tick();
    idle(2);

    set(0, 1, 0, 0, 6'd9, 16'h0); tick();
    set(0, 0, 0, 0, 6'd0, 16'h0);
    n_rst = 1'b1; tick();
    n_rst = 1'b0;
    set(0, 1, 0, 0, 6'd12, 16'h0);
    set(1, 1, 0, 0, 6'd13, 16'h0); tick();
    chk("post_reset_tie", 32'(mg), 32'd0);
    idle(2);

    gen(0); gen(1);
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) n_rst = 1'b1;
      tick();
      n_rst = 1'b0;
      if (mg == 0 || !s_req[0]) gen(0);
      if (mg == 1 || !s_req[1]) gen(1);
    end
    idle(3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
